// File: rtl/sol1_microsequencer_pkg.sv
// pa_microcode: shared constants and types for the microcode sequencer.
//   - Micro-address layout {esc_page, opcode, cycle} and its widths.
//   - Entry addresses of the fetch, interrupt and DMA routines.
//   - Control-word sequencing types (typ field) and condition selector codes.
// Optional feature macro (used by the sequencer files): SOL1_USEQ_TRACE_EN.
package pa_microcode;

    localparam int OPC_W       = 8;
    localparam int CYC_W       = 6;
    localparam int UADDR_W     = 1 + OPC_W + CYC_W;
    localparam int TRACE_DEPTH = 8;

    localparam logic [UADDR_W-1:0] FETCH_ENTRY = 15'h0000;
    localparam logic [UADDR_W-1:0] INT_ENTRY   = 15'h0040;
    localparam logic [UADDR_W-1:0] DMA_ENTRY   = 15'h0080;

    typedef enum logic [1:0] {
        TYP_OFFSET    = 2'b00,
        TYP_BRANCH    = 2'b01,
        TYP_PREFETCH  = 2'b10,
        TYP_POSTFETCH = 2'b11
    } typ_e;

    // Codes 0..6 evaluate against the flag set chosen by cond_flag_src.
    localparam logic [3:0] COND_ZF    = 4'd0;
    localparam logic [3:0] COND_CF    = 4'd1;
    localparam logic [3:0] COND_SF    = 4'd2;
    localparam logic [3:0] COND_OF    = 4'd3;
    localparam logic [3:0] COND_LE    = 4'd4;   // ZF | (SF ^ OF)
    localparam logic [3:0] COND_LT    = 4'd5;   // SF ^ OF
    localparam logic [3:0] COND_BE    = 4'd6;   // CF | ZF
    localparam logic [3:0] COND_DMA   = 4'd7;
    localparam logic [3:0] COND_MODE  = 4'd8;
    localparam logic [3:0] COND_WAIT  = 4'd9;
    localparam logic [3:0] COND_INT   = 4'd10;  // int_pending & irq_en
    localparam logic [3:0] COND_DIR   = 4'd11;
    localparam logic [3:0] COND_IR0   = 4'd12;
    localparam logic [3:0] COND_ZZ    = 4'd13;  // st_zf & u_zf
    localparam logic [3:0] COND_FALSE = 4'd14;
    localparam logic [3:0] COND_TRUE  = 4'd15;

endpackage

// File: rtl/sol1_microsequencer_if.sv
// sol1_microsequencer_if: bundle between the control-word/CPU side (master)
// and the microsequencer (slave).
//   master drives: control-word sequencing fields (typ, u_offset, cond_*,
//     escape), ir_opcode, status and micro flags, CPU status inputs, hold.
//   slave drives: u_addr (registered), cond_true (combinational), esc_page.
//   With SOL1_USEQ_TRACE_EN: master drives trace_idx, slave drives trace_data.
// Handshake: there is no valid/ready pair. Every clk edge with hold=0 consumes
// the control word present on the fields and registers a new u_addr; hold=1
// stalls the sequencer. u_addr is always valid and its ROM word is expected
// back on the fields combinationally within the same cycle.
interface sol1_microsequencer_if;
    import pa_microcode::*;

    logic [1:0]         typ;
    logic [6:0]         u_offset;
    logic               cond_invert;
    logic               cond_flag_src;
    logic [3:0]         cond_sel;
    logic               escape;
    logic [OPC_W-1:0]   ir_opcode;
    logic               st_zf, st_cf, st_sf, st_of;
    logic               u_zf, u_cf, u_sf, u_of;
    logic               dma_req, int_pending, irq_en, cpu_mode, cpu_dir, ext_wait;
    logic               hold;
    logic [UADDR_W-1:0] u_addr;
    logic               cond_true;
    logic               esc_page;
`ifdef SOL1_USEQ_TRACE_EN
    logic [2:0]           trace_idx;
    logic [2*UADDR_W-1:0] trace_data;

    modport master (
        output typ, u_offset, cond_invert, cond_flag_src, cond_sel, escape, ir_opcode,
        output st_zf, st_cf, st_sf, st_of, u_zf, u_cf, u_sf, u_of,
        output dma_req, int_pending, irq_en, cpu_mode, cpu_dir, ext_wait, hold,
        output trace_idx,
        input  u_addr, cond_true, esc_page, trace_data
    );
    modport slave (
        input  typ, u_offset, cond_invert, cond_flag_src, cond_sel, escape, ir_opcode,
        input  st_zf, st_cf, st_sf, st_of, u_zf, u_cf, u_sf, u_of,
        input  dma_req, int_pending, irq_en, cpu_mode, cpu_dir, ext_wait, hold,
        input  trace_idx,
        output u_addr, cond_true, esc_page, trace_data
    );
`else
    modport master (
        output typ, u_offset, cond_invert, cond_flag_src, cond_sel, escape, ir_opcode,
        output st_zf, st_cf, st_sf, st_of, u_zf, u_cf, u_sf, u_of,
        output dma_req, int_pending, irq_en, cpu_mode, cpu_dir, ext_wait, hold,
        input  u_addr, cond_true, esc_page
    );
    modport slave (
        input  typ, u_offset, cond_invert, cond_flag_src, cond_sel, escape, ir_opcode,
        input  st_zf, st_cf, st_sf, st_of, u_zf, u_cf, u_sf, u_of,
        input  dma_req, int_pending, irq_en, cpu_mode, cpu_dir, ext_wait, hold,
        output u_addr, cond_true, esc_page
    );
`endif

endinterface

// File: rtl/sol1_useq_cond.sv
// sol1_useq_cond: combinational branch-condition mux with optional inversion.
//   cond_sel_i      condition code (see COND_* in pa_microcode)
//   cond_flag_src_i 0 = status flags, 1 = micro flags, for codes 0..6
//   cond_invert_i   inverts the selected condition
//   st_*_i, u_*_i   status and micro flags
//   dma_req_i .. ir0_i  CPU status inputs
//   cond_true_o     selected condition XOR cond_invert_i
module sol1_useq_cond
    import pa_microcode::*;
(
    input  logic [3:0] cond_sel_i,
    input  logic       cond_flag_src_i,
    input  logic       cond_invert_i,
    input  logic       st_zf_i,
    input  logic       st_cf_i,
    input  logic       st_sf_i,
    input  logic       st_of_i,
    input  logic       u_zf_i,
    input  logic       u_cf_i,
    input  logic       u_sf_i,
    input  logic       u_of_i,
    input  logic       dma_req_i,
    input  logic       int_pending_i,
    input  logic       irq_en_i,
    input  logic       cpu_mode_i,
    input  logic       cpu_dir_i,
    input  logic       ext_wait_i,
    input  logic       ir0_i,
    output logic       cond_true_o
);

    logic f_zf, f_cf, f_sf, f_of;
    logic c;

    assign f_zf = cond_flag_src_i ? u_zf_i : st_zf_i;
    assign f_cf = cond_flag_src_i ? u_cf_i : st_cf_i;
    assign f_sf = cond_flag_src_i ? u_sf_i : st_sf_i;
    assign f_of = cond_flag_src_i ? u_of_i : st_of_i;

    always_comb begin
        c = 1'b0;
        case (cond_sel_i)
            COND_ZF:    c = f_zf;
            COND_CF:    c = f_cf;
            COND_SF:    c = f_sf;
            COND_OF:    c = f_of;
            COND_LE:    c = f_zf | (f_sf ^ f_of);
            COND_LT:    c = f_sf ^ f_of;
            COND_BE:    c = f_cf | f_zf;
            COND_DMA:   c = dma_req_i;
            COND_MODE:  c = cpu_mode_i;
            COND_WAIT:  c = ext_wait_i;
            COND_INT:   c = int_pending_i & irq_en_i;
            COND_DIR:   c = cpu_dir_i;
            COND_IR0:   c = ir0_i;
            COND_ZZ:    c = st_zf_i & u_zf_i;   // always both sets, ignores cond_flag_src
            COND_FALSE: c = 1'b0;
            COND_TRUE:  c = 1'b1;
            default:    c = 1'b0;
        endcase
    end

    assign cond_true_o = c ^ cond_invert_i;

endmodule

// File: rtl/sol1_microsequencer.sv
// sol1_microsequencer: generates the registered micro-address for the microcode
// ROM, one microinstruction per clock.
//   clk, rst_n   clock, synchronous active-low reset (wins over hold)
//   bus (slave)  control-word fields, flags and CPU status in;
//                u_addr / cond_true / esc_page out
// Optional macro SOL1_USEQ_TRACE_EN adds an 8-entry trace of non-sequential
// transfers {from, to}, read by bus.trace_idx (0 = newest) on bus.trace_data.
module sol1_microsequencer
    import pa_microcode::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    sol1_microsequencer_if.slave bus
);

    logic [UADDR_W-1:0] u_addr_q, u_addr_d;
    logic               esc_page_q, esc_page_d;
    logic [UADDR_W-1:0] seq_addr;
    logic [UADDR_W-1:0] off_addr;
    logic               cond_true;
    typ_e               typ;

    assign typ = typ_e'(bus.typ);

    sol1_useq_cond u_cond (
        .cond_sel_i      (bus.cond_sel),
        .cond_flag_src_i (bus.cond_flag_src),
        .cond_invert_i   (bus.cond_invert),
        .st_zf_i         (bus.st_zf),
        .st_cf_i         (bus.st_cf),
        .st_sf_i         (bus.st_sf),
        .st_of_i         (bus.st_of),
        .u_zf_i          (bus.u_zf),
        .u_cf_i          (bus.u_cf),
        .u_sf_i          (bus.u_sf),
        .u_of_i          (bus.u_of),
        .dma_req_i       (bus.dma_req),
        .int_pending_i   (bus.int_pending),
        .irq_en_i        (bus.irq_en),
        .cpu_mode_i      (bus.cpu_mode),
        .cpu_dir_i       (bus.cpu_dir),
        .ext_wait_i      (bus.ext_wait),
        .ir0_i           (bus.ir_opcode[0]),
        .cond_true_o     (cond_true)
    );

    // Both adders wrap modulo 2^UADDR_W by construction.
    assign seq_addr = u_addr_q + UADDR_W'(1);
    assign off_addr = u_addr_q + {{(UADDR_W-7){bus.u_offset[6]}}, bus.u_offset};

    always_comb begin
        u_addr_d   = u_addr_q;
        esc_page_d = esc_page_q;
        if (!bus.hold) begin
            case (typ)
                TYP_OFFSET: begin
                    u_addr_d = cond_true ? off_addr : seq_addr;
                end
                TYP_BRANCH: begin
                    // Jump stays inside the current opcode slot.
                    u_addr_d = cond_true ? {u_addr_q[UADDR_W-1:CYC_W], bus.u_offset[CYC_W-1:0]}
                                         : seq_addr;
                end
                TYP_PREFETCH: begin
                    // DMA and interrupts are only recognised here, between instructions.
                    if (bus.dma_req) begin
                        u_addr_d = DMA_ENTRY;
                    end else if (bus.int_pending && bus.irq_en) begin
                        u_addr_d = INT_ENTRY;
                    end else begin
                        u_addr_d = FETCH_ENTRY;
                    end
                    esc_page_d = 1'b0;
                end
                TYP_POSTFETCH: begin
                    if (bus.escape) begin
                        // Escape prefix: fetch the second opcode byte on the upper page.
                        u_addr_d   = FETCH_ENTRY + UADDR_W'(1);
                        esc_page_d = 1'b1;
                    end else begin
                        u_addr_d   = {esc_page_q, bus.ir_opcode, {CYC_W{1'b0}}};
                        esc_page_d = 1'b0;
                    end
                end
                default: begin
                    u_addr_d = seq_addr;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            u_addr_q   <= FETCH_ENTRY;
            esc_page_q <= 1'b0;
        end else begin
            u_addr_q   <= u_addr_d;
            esc_page_q <= esc_page_d;
        end
    end

    assign bus.u_addr    = u_addr_q;
    assign bus.esc_page  = esc_page_q;
    assign bus.cond_true = cond_true;

`ifdef SOL1_USEQ_TRACE_EN
    logic [2*UADDR_W-1:0] trace_q [TRACE_DEPTH];
    logic [2:0]           wr_ptr_q;
    logic [2:0]           rd_ptr;
    logic                 trace_wr;

    // Record every transfer that is not a plain sequential step.
    assign trace_wr = !bus.hold && (u_addr_d != seq_addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 3'd0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_q[i] <= '0;
            end
        end else if (trace_wr) begin
            trace_q[wr_ptr_q] <= {u_addr_q, u_addr_d};
            wr_ptr_q          <= wr_ptr_q + 3'd1;
        end
    end

    // 3-bit arithmetic gives the circular wrap; idx 0 is the newest entry.
    assign rd_ptr         = wr_ptr_q - 3'd1 - bus.trace_idx;
    assign bus.trace_data = trace_q[rd_ptr];
`endif

endmodule

// File: tb/tb_sol1_microsequencer.sv
// Bench for sol1_microsequencer: directed control words with hand-computed
// {esc_page, u_addr, cond_true} results, checked by a negedge monitor.
module tb_sol1_microsequencer;
    import pa_microcode::*;

    localparam int EW = 2 + UADDR_W;  // {esc_page, u_addr, cond_true}

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sol1_microsequencer_if bus ();

    sol1_microsequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp, mon_got;
    int            n_cmp  = 0;
    int            n_fail = 0;
`ifdef SOL1_USEQ_TRACE_EN
    logic [2*UADDR_W-1:0] exp_tr_q[$];
    logic [2*UADDR_W-1:0] tr_exp;
`endif

    // ---------------- driver tasks ----------------
    task automatic cw(input logic [1:0] t, input logic [6:0] off, input logic [3:0] sel,
                      input logic inv, input logic src, input logic esc);
        bus.typ           = t;
        bus.u_offset      = off;
        bus.cond_sel      = sel;
        bus.cond_invert   = inv;
        bus.cond_flag_src = src;
        bus.escape        = esc;
    endtask

    task automatic clr_flags();
        bus.st_zf = 0; bus.st_cf = 0; bus.st_sf = 0; bus.st_of = 0;
        bus.u_zf  = 0; bus.u_cf  = 0; bus.u_sf  = 0; bus.u_of  = 0;
        bus.dma_req = 0; bus.int_pending = 0; bus.irq_en = 0;
        bus.cpu_mode = 0; bus.cpu_dir = 0; bus.ext_wait = 0;
    endtask

    // One clock with the currently applied inputs; expectation is queued
    // for the monitor, inputs may change again 1 time unit after negedge.
    task automatic tick(input logic [UADDR_W-1:0] a, input logic e, input logic c);
        @(posedge clk);
        exp_q.push_back({e, a, c});
        @(negedge clk);
        #1;
    endtask

`ifdef SOL1_USEQ_TRACE_EN
    task automatic tick_tr(input logic [UADDR_W-1:0] a, input logic [2*UADDR_W-1:0] td);
        @(posedge clk);
        exp_q.push_back({1'b0, a, 1'b1});
        exp_tr_q.push_back(td);
        @(negedge clk);
        #1;
    endtask
`endif

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {bus.esc_page, bus.u_addr, bus.cond_true};
            n_cmp++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL seq%0d {esc,u_addr,cond}: got %0h/%04h/%0b required %0h/%04h/%0b",
                         n_cmp, mon_got[EW-1], mon_got[EW-2:1], mon_got[0],
                         mon_exp[EW-1], mon_exp[EW-2:1], mon_exp[0]);
            end
        end
`ifdef SOL1_USEQ_TRACE_EN
        if (exp_tr_q.size() > 0) begin
            tr_exp = exp_tr_q.pop_front();
            n_cmp++;
            if (bus.trace_data !== tr_exp) begin
                n_fail++;
                $display("FAIL trace idx%0d: got %08h required %08h",
                         bus.trace_idx, bus.trace_data, tr_exp);
            end
        end
`endif
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n         = 1'b0;
        bus.hold      = 1'b0;
        bus.ir_opcode = 8'h00;
`ifdef SOL1_USEQ_TRACE_EN
        bus.trace_idx = 3'd0;
`endif
        clr_flags();
        cw(2'b01, 7'h00, 4'd15, 0, 0, 0);

        // Reset held 2 clocks while a taken BRANCH is presented.
        tick(15'h0000, 0, 1);
        tick(15'h0000, 0, 1);
        rst_n = 1'b1;
        cw(2'b00, 7'h00, 4'd14, 0, 0, 0);
        tick(15'h0001, 0, 0);

        // Reach 0x0105: dispatch opcode 0x04 then branch to cycle 5.
        bus.ir_opcode = 8'h04;
        cw(2'b11, 7'h00, 4'd14, 0, 0, 0); tick(15'h0100, 0, 0);
        cw(2'b01, 7'h05, 4'd15, 0, 0, 0); tick(15'h0105, 0, 1);

        // OFFSET with -2.
        bus.st_zf = 1;
        cw(2'b00, 7'h7E, 4'd0, 0, 0, 0);  tick(15'h0103, 0, 1);
        cw(2'b01, 7'h05, 4'd15, 0, 0, 0); tick(15'h0105, 0, 1);
        bus.st_zf = 0;
        cw(2'b00, 7'h7E, 4'd0, 0, 0, 0);  tick(15'h0106, 0, 0);
        cw(2'b01, 7'h05, 4'd15, 0, 0, 0); tick(15'h0105, 0, 1);
        cw(2'b00, 7'h7E, 4'd0, 1, 0, 0);  tick(15'h0103, 0, 1);
        // BRANCH ignores u_offset[6].
        cw(2'b01, 7'h45, 4'd15, 0, 0, 0); tick(15'h0105, 0, 1);

        // Dispatch, plain and via escape page.
        bus.ir_opcode = 8'h3A;
        cw(2'b11, 7'h00, 4'd14, 0, 0, 0); tick(15'h0E80, 0, 0);
        cw(2'b11, 7'h00, 4'd14, 0, 0, 1); tick(15'h0001, 1, 0);
        cw(2'b00, 7'h00, 4'd14, 0, 0, 0); tick(15'h0002, 1, 0);
        cw(2'b11, 7'h00, 4'd14, 0, 0, 0); tick(15'h4E80, 0, 0);

        // PREFETCH priority; conditions ignored; esc_page cleared.
        bus.dma_req = 1; bus.int_pending = 1; bus.irq_en = 1;
        cw(2'b10, 7'h00, 4'd15, 0, 0, 0); tick(15'h0080, 0, 1);
        bus.dma_req = 0;
        tick(15'h0040, 0, 1);
        cw(2'b11, 7'h00, 4'd14, 0, 0, 1); tick(15'h0001, 1, 0);
        bus.irq_en = 0;
        cw(2'b10, 7'h00, 4'd15, 0, 0, 0); tick(15'h0000, 0, 1);
        clr_flags();

        // Hold freezes; hold beats DMA at PREFETCH.
        cw(2'b01, 7'h09, 4'd15, 0, 0, 0); tick(15'h0009, 0, 1);
        bus.hold = 1;
        cw(2'b00, 7'h05, 4'd15, 0, 0, 0);
        repeat (3) tick(15'h0009, 0, 1);
        bus.dma_req = 1;
        cw(2'b10, 7'h00, 4'd15, 0, 0, 0); tick(15'h0009, 0, 1);
        bus.hold = 0;
        tick(15'h0080, 0, 1);
        bus.dma_req = 0;

        // Condition codes, branching inside slot 0x0080.
        bus.u_sf = 1;
        cw(2'b01, 7'h10, 4'd4, 0, 1, 0);  tick(15'h0090, 0, 1);
        cw(2'b01, 7'h10, 4'd4, 0, 0, 0);  tick(15'h0091, 0, 0);
        bus.u_sf = 0; bus.st_zf = 1;
        cw(2'b01, 7'h20, 4'd13, 0, 0, 0); tick(15'h0092, 0, 0);
        bus.u_zf = 1;
        tick(15'h00A0, 0, 1);
        clr_flags();
        bus.ir_opcode = 8'h3B;
        cw(2'b01, 7'h30, 4'd12, 0, 0, 0); tick(15'h00B0, 0, 1);
        bus.u_cf = 1;
        cw(2'b01, 7'h30, 4'd6, 1, 1, 0);  tick(15'h00B1, 0, 0);
        bus.u_cf = 0; bus.int_pending = 1;
        cw(2'b01, 7'h01, 4'd10, 0, 0, 0); tick(15'h00B2, 0, 0);
        bus.irq_en = 1;
        tick(15'h0081, 0, 1);
        clr_flags(); bus.ext_wait = 1;
        cw(2'b01, 7'h3F, 4'd9, 0, 0, 0);  tick(15'h00BF, 0, 1);
        bus.ext_wait = 0; bus.cpu_dir = 1;
        cw(2'b01, 7'h00, 4'd11, 0, 0, 0); tick(15'h0080, 0, 1);
        bus.cpu_dir = 0;
        cw(2'b00, 7'h01, 4'd8, 0, 0, 0);  tick(15'h0081, 0, 0);

        // Address wrap at both ends.
        cw(2'b11, 7'h00, 4'd14, 0, 0, 1); tick(15'h0001, 1, 0);
        bus.ir_opcode = 8'hFF;
        cw(2'b11, 7'h00, 4'd14, 0, 0, 0); tick(15'h7FC0, 0, 0);
        cw(2'b01, 7'h3F, 4'd15, 0, 0, 0); tick(15'h7FFF, 0, 1);
        cw(2'b00, 7'h7F, 4'd14, 0, 0, 0); tick(15'h0000, 0, 0);
        cw(2'b00, 7'h7E, 4'd15, 0, 0, 0); tick(15'h7FFE, 0, 1);
        cw(2'b00, 7'h02, 4'd15, 0, 0, 0); tick(15'h0000, 0, 1);

        // Reset mid-routine beats hold and a taken branch.
        cw(2'b11, 7'h00, 4'd14, 0, 0, 1); tick(15'h0001, 1, 0);
        bus.hold = 1; rst_n = 0;
        cw(2'b01, 7'h3F, 4'd15, 0, 0, 0); tick(15'h0000, 0, 1);
        bus.hold = 0; rst_n = 1;

        // Nine taken branches in slot 0x0400 (step 2 so none is sequential).
        bus.ir_opcode = 8'h10;
        cw(2'b11, 7'h00, 4'd14, 0, 0, 0); tick(15'h0400, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            cw(2'b01, 7'(2 * k), 4'd15, 0, 0, 0);
            tick(UADDR_W'(16'h0400 + 2 * k), 0, 1);
        end
`ifdef SOL1_USEQ_TRACE_EN
        bus.hold = 1;
        bus.trace_idx = 3'd0; tick_tr(15'h0412, {15'h0410, 15'h0412});
        bus.trace_idx = 3'd1; tick_tr(15'h0412, {15'h040E, 15'h0410});
        bus.trace_idx = 3'd7; tick_tr(15'h0412, {15'h0402, 15'h0404});
        bus.hold = 0;
`endif

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sol1_microsequencer.md
Name: sol1_microsequencer

Overview:
- Generates the micro-address that indexes the 14-byte microcode ROM (control word).
- Consumes the sequencing fields of the current control word: typ, u_offset, cond_*, ESCAPE.
- Evaluates branch conditions against the status flags or the micro flags.
- Dispatches on the IR opcode and registers the next micro-address each clock.

Parameters:
- OPC_W, 8, opcode width used for dispatch.
- CYC_W, 6, micro-cycle bits per opcode slot.
- UADDR_W, 1+OPC_W+CYC_W (15), micro-address width: {esc_page, opcode, cycle}.
- FETCH_ENTRY, 15'h0000, fetch routine entry address.
- INT_ENTRY, 15'h0040, interrupt-entry routine address.
- DMA_ENTRY, 15'h0080, DMA-grant routine address.

Ports:
- clk in 1: clock.
- rst_n in 1: synchronous reset, active low.
- typ in 2: control-word sequencing type.
- u_offset in 7: control-word offset/target field.
- cond_invert in 1: inverts the selected condition.
- cond_flag_src in 1: selects flag set for conditions 0..6; 0 = status flags, 1 = micro flags.
- cond_sel in 4: condition selector.
- escape in 1: control-word ESCAPE bit.
- ir_opcode in OPC_W: instruction register contents.
- st_zf, st_cf, st_sf, st_of in 1 each: status flags.
- u_zf, u_cf, u_sf, u_of in 1 each: micro flags.
- dma_req, int_pending, irq_en, cpu_mode, cpu_dir, ext_wait in 1 each: CPU status and condition inputs.
- hold in 1: freeze sequencing.
- u_addr out UADDR_W: registered micro-address to the ROM.
- cond_true out 1: evaluated condition for the current word, for debug.
- esc_page out 1: active opcode page.

Behaviour:
- Reset on clk with rst_n=0:
  - u_addr=FETCH_ENTRY, esc_page=0.
  - cond_true is combinational; it reflects the control-word inputs present during reset.
  - Reset wins over hold and over every typ action, including mid-routine.
- Latency: u_addr changes only on clk. The ROM word for u_addr is presented combinationally on the field inputs, so there is exactly one microinstruction per cycle.
- Condition c by cond_sel; for 0..6, F = micro flags if cond_flag_src else status flags:
  - 0 ZF, 1 CF, 2 SF, 3 OF, 4 ZF|(SF^OF), 5 SF^OF, 6 CF|ZF.
  - 7 dma_req, 8 cpu_mode, 9 ext_wait, 10 int_pending&irq_en, 11 cpu_dir, 12 ir_opcode[0].
  - 13 st_zf&u_zf, 14 0, 15 1.
  - cond_true = c ^ cond_invert.
- Next address when hold=0:
  - typ=00 (OFFSET):
    - cond_true: u_addr + sext(u_offset[6:0]), modulo 2^UADDR_W. Wrap from 0x7FFF+1 to 0x0000 is legal and not flagged.
    - else: u_addr+1, same wrap.
  - typ=01 (BRANCH):
    - cond_true: {u_addr[UADDR_W-1:CYC_W], u_offset[CYC_W-1:0]}. This is an intra-slot jump; u_offset[6] is ignored.
    - else: u_addr+1.
  - typ=10 (PREFETCH), priority order:
    1. dma_req → DMA_ENTRY.
    2. int_pending&irq_en → INT_ENTRY.
    3. Otherwise → FETCH_ENTRY.
    - Clears esc_page. Conditions are ignored.
  - typ=11 (POSTFETCH):
    - escape=1: esc_page_next=1, u_addr_next=FETCH_ENTRY+1 (second byte fetch).
    - escape=0: u_addr_next={esc_page, ir_opcode, CYC_W'0}, then esc_page clears to 0.
- hold=1:
  - u_addr and esc_page retained; no other state changes.
  - Simultaneous hold and dma_req: hold wins. The request is sampled on the first non-hold PREFETCH.
- Interrupt and DMA are recognised only at PREFETCH, never mid-instruction.

Optional Feature:
- Macro: SOL1_USEQ_TRACE_EN.
- Enabled:
  - Adds an 8-entry circular trace buffer, with ports trace_idx in 3 and trace_data out 2*UADDR_W.
  - On every clock edge where hold=0 and u_addr_next ≠ u_addr+1, writes {u_addr, u_addr_next} at wr_ptr, then wr_ptr++ (wraps 7→0; oldest entry overwritten).
  - trace_data = entry[wr_ptr-1-trace_idx]: combinational read, idx 0 = newest.
  - Reset clears wr_ptr and all entries to 0.
- Disabled: neither port exists and no storage is inferred.

Decomposition:
- Add to pa_microcode:
  - typ enum: TYP_OFFSET=2'b00, TYP_BRANCH=2'b01, TYP_PREFETCH=2'b10, TYP_POSTFETCH=2'b11.
  - cond_sel localparams COND_ZF..COND_TRUE.
  - UADDR_W and the three entry addresses.
- One sub-module: sol1_useq_cond, a purely combinational condition mux/invert. The address register, esc_page and the trace buffer stay in the top.

Test Plan:
- Reset:
  - rst_n=0 for 2 clocks while typ=01, cond_sel=15 → u_addr=0x0000, esc_page=0.
  - Release → the following sequence steps from 0.
- Offset:
  - u_addr=0x0105, typ=00, cond_sel=0, cond_flag_src=0, st_zf=1, u_offset=7'h7E (-2) → u_addr=0x0103.
  - Same with st_zf=0 → 0x0106.
  - cond_invert=1 with st_zf=0 → 0x0103.
- Dispatch:
  - typ=11, escape=0, ir_opcode=0x3A, esc_page=0 → u_addr=0x0E80.
  - With escape=1 first → u_addr=0x0001, esc_page=1; then typ=11, escape=0, ir=0x3A → u_addr=0x4E80, esc_page=0.
- Prefetch priority:
  - typ=10, dma_req=1, int_pending=1, irq_en=1 → 0x0080.
  - dma_req=0 → 0x0040.
  - irq_en=0 → 0x0000.
- Hold/wrap:
  - hold=1 for 3 clocks with typ=00 → u_addr unchanged.
  - u_addr=0x7FFF, typ=00, cond false → 0x0000.
- Trace (with SOL1_USEQ_TRACE_EN):
  - 9 taken branches → trace_idx=0 returns the 9th {from,to}.
  - trace_idx=7 returns the 2nd; the 1st is overwritten.
